decoder_scan_seq: RTL
=====================

// Module: decoder_scan_seq
// PURPOSE
//   Upstream sequencer for the 2-to-4 enable decoder. It produces the 2-bit select A and the enable E
//   that step the decoder through its four one-hot outputs in round-robin order.
//   Each active channel is held for a programmable dwell time, followed by an optional blanking gap with E low.
//   Supports single-sweep and continuous modes, a per-channel skip mask, a stop control and a sweep-done pulse.
// PARAMETERS
//   DWELL   4   cycles E=1 per channel; legal range >=1
//   BLANK   1   cycles E=0 after each dwell; legal range >=0; 0 means back-to-back channels
// PORTS
//   clk     in   1  single clock; all logic on rising edge
//   rst     in   1  synchronous, active-high reset
//   start   in   1  begin a sweep; sampled only in IDLE
//   stop    in   1  abort the scan; sampled in every non-IDLE state
//   cont    in   1  1=continuous sweeps, 0=single sweep; sampled at each sweep boundary
//   mask    in   4  1=channel enabled; latched at start and at each sweep boundary
//   A       out  2  channel index to decoder
//   E       out  1  decoder enable
//   busy    out  1  high while in ACTIVE or GAP
//   done    out  1  one-cycle pulse when a sweep completes
// BEHAVIOUR
//   Reset values: A=0, E=0, busy=0, done=0; state=IDLE; counters=0; latched mask=0.
//   States: IDLE, ACTIVE (E=1), GAP (E=0, busy=1).
//   IDLE + start + mask!=0:
//     - next cycle enter ACTIVE with A = lowest set bit of mask, E=1, busy=1.
//     - latency is 1 cycle.
//   IDLE + start + mask==0: ignored; stay IDLE; no done pulse.
//   ACTIVE: hold A and E=1 for exactly DWELL cycles, then:
//     - if BLANK>0: go to GAP for BLANK cycles; A holds, E=0.
//     - if BLANK==0: advance immediately with no E=0 cycle between channels.
//   Advance: next set bit of the latched mask above A, ascending. A changes only on entry to ACTIVE.
//   Sweep end: occurs when no set bit lies above A.
//     - In the next cycle, done=1.
//     - If cont=1: re-latch mask; if the new mask!=0, enter ACTIVE at its lowest set bit in that same cycle
//       (E=1, busy=1). This makes the sweep period exactly n*(DWELL+BLANK) for n set bits.
//     - If cont=0, or the new mask==0: go to IDLE with E=0, busy=0; A holds its last value.
//   mask changes mid-sweep are ignored until the next sweep boundary.
//   stop in ACTIVE or GAP: next cycle IDLE, E=0, busy=0, A holds, no done pulse.
//   stop and start in the same cycle: stop wins. start while busy is ignored.
//   stop in the same cycle as a sweep end: stop wins; done is suppressed.
//   rst mid-operation: reset values at the next edge; overrides start and stop.
//   Counter width: $clog2(DWELL+BLANK+1); no wrap beyond the terminal count.
//   E is never high in IDLE. Exactly one channel is active per dwell. A never selects a masked channel while E=1.
// CONFIGURATION
//   SCAN_SWEEP_CNT_EN defined:
//     - adds output port sweep_cnt [7:0], reset 0.
//     - increments in the same cycle done=1; wraps 255->0.
//     - cleared on an IDLE->ACTIVE start; holds on stop.
//   SCAN_SWEEP_CNT_EN undefined:
//     - no sweep_cnt port and no counter logic; all other behaviour identical.
// TESTING
//   1. Reset: rst=1 for 2 cycles with start=1 -> A=0, E=0, busy=0, done=0 throughout.
//   2. Single sweep, DWELL=4, BLANK=1, mask=4'b1111, cont=0, start pulse at cycle 0:
//      - E=1 at cycles 1-4 (A=0), 6-9 (A=1), 11-14 (A=2), 16-19 (A=3).
//      - E=0 at cycles 5, 10, 15, 20.
//      - done=1 and busy=0 at cycle 21.
//   3. mask=4'b1010, BLANK=0, cont=0:
//      - A=1 for 4 cycles, then A=3 for 4 cycles, with no E=0 gap.
//      - done after 8 active cycles; A=0 and A=2 never appear.
//   4. cont=1, mask=4'b1111, defaults:
//      - done pulses every 20 cycles; E=1 with A=0 in the done cycle.
//      - a mask change to 4'b0001 mid-sweep takes effect only after the next done.
//   5. stop asserted during A=2 dwell:
//      - next cycle E=0, busy=0, A=2, no done pulse.
//      - start and stop in the same IDLE cycle -> stays IDLE.
//   6. With SCAN_SWEEP_CNT_EN, run 3 continuous sweeps:
//      - sweep_cnt = 1, 2, 3 at successive done pulses.
//      - a new start clears it to 0.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// Round-robin sequencer driving the select/enable inputs of a 2-to-4 enable decoder.
// Optional sweep counter output enabled by defining SCAN_SWEEP_CNT_EN.
module decoder_scan_seq #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] mask,
  output logic [1:0] A,
  output logic       E,
  output logic       busy,
  output logic       done
`ifdef SCAN_SWEEP_CNT_EN
  ,
  output logic [7:0] sweep_cnt
`endif
);

  localparam int unsigned CntW = (DWELL + BLANK + 1 > 1) ? $clog2(DWELL + BLANK + 1) : 1;
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] BlankLast = (BLANK > 0) ? CntW'(BLANK - 1) : '0;

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      a_q, a_d;
  logic [3:0]      mask_q, mask_d;
  logic            done_q, done_d;
  logic            start_ok;
  logic            advance;
  logic [3:0]      above_mask;

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign start_ok   = (state_q == StIdle) && start && !stop && (mask != 4'b0000);
  // Enabled channels strictly above the current one.
  assign above_mask = mask_q & (4'b1110 << a_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StActive;
          a_d     = low_bit(mask);
          mask_d  = mask;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DwellLast) begin
          if (BLANK > 0) begin
            state_d = StGap;
            cnt_d   = '0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      cnt_d = '0;
      if (above_mask != 4'b0000) begin
        state_d = StActive;
        a_d     = low_bit(above_mask);
      end else begin
        // Sweep boundary: report completion and re-latch the mask.
        done_d = 1'b1;
        mask_d = mask;
        if (cont && (mask != 4'b0000)) begin
          state_d = StActive;
          a_d     = low_bit(mask);
        end else begin
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= 2'd0;
      mask_q  <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign E    = (state_q == StActive);
  assign busy = (state_q != StIdle);
  assign done = done_q;

`ifdef SCAN_SWEEP_CNT_EN
  logic [7:0] sweep_cnt_q, sweep_cnt_d;

  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    if (start_ok)    sweep_cnt_d = 8'd0;
    else if (done_d) sweep_cnt_d = sweep_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sweep_cnt_q <= 8'd0;
    else     sweep_cnt_q <= sweep_cnt_d;
  end

  assign sweep_cnt = sweep_cnt_q;
`endif

endmodule
